// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single reads to a variable-latency
// instruction memory and presents fetched instructions through the IF/ID register.
module if_stage #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter logic [15:0] HALT_OP  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [7:0]  redirect_pc,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    output logic        imem_rd_en,
    output logic [7:0]  imem_addr,
    output logic [15:0] instruction_output,
    output logic        instr_valid,
    output logic [7:0]  pc_out,
    output logic        halted
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_r;
    logic [7:0]  pc_r;
    logic        discard_r;
    logic [15:0] skid_instr_r;
    logic [7:0]  skid_pc_r;
    logic        skid_valid_r;
    logic [15:0] instr_r;
    logic        valid_r;
    logic [7:0]  pc_out_r;
    logic        halted_r;

    logic        load_en_s;
    logic [15:0] load_instr_s;
    logic [7:0]  load_pc_s;

    // Select the source of an IF/ID load: a fresh memory response or the skid buffer.
    always_comb begin
        load_en_s    = 1'b0;
        load_instr_s = imem_data;
        load_pc_s    = pc_r;
        if ((state_r == WAIT) && imem_valid && !discard_r && !stall) begin
            load_en_s = 1'b1;
        end else if ((state_r == HOLD) && skid_valid_r && !stall) begin
            load_en_s    = 1'b1;
            load_instr_s = skid_instr_r;
            load_pc_s    = skid_pc_r;
        end else begin
            load_en_s = 1'b0;
        end
    end

    // Fetch FSM, skid buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ISSUE;
            pc_r         <= RESET_PC;
            discard_r    <= 1'b0;
            skid_instr_r <= 16'h0000;
            skid_pc_r    <= 8'h00;
            skid_valid_r <= 1'b0;
            instr_r      <= 16'h0000;
            valid_r      <= 1'b0;
            pc_out_r     <= 8'h00;
            halted_r     <= 1'b0;
        end else if (redirect_en) begin
            pc_r         <= redirect_pc;
            instr_r      <= 16'h0000;
            valid_r      <= 1'b0;
            skid_instr_r <= 16'h0000;
            skid_pc_r    <= 8'h00;
            skid_valid_r <= 1'b0;
            halted_r     <= 1'b0;
            // An outstanding request must be swallowed when it finally returns.
            if ((state_r == WAIT) && !imem_valid) begin
                state_r   <= WAIT;
                discard_r <= 1'b1;
            end else begin
                state_r   <= ISSUE;
                discard_r <= 1'b0;
            end
        end else begin
            if (load_en_s) begin
                instr_r  <= load_instr_s;
                valid_r  <= 1'b1;
                pc_out_r <= load_pc_s;
                pc_r     <= pc_r + 8'd1;
            end else if (!stall) begin
                instr_r <= 16'h0000;
                valid_r <= 1'b0;
            end else begin
                instr_r <= instr_r;
                valid_r <= valid_r;
            end

            case (state_r)
                ISSUE: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (imem_valid && discard_r) begin
                        discard_r <= 1'b0;
                        state_r   <= ISSUE;
                    end else if (imem_valid && stall) begin
                        skid_instr_r <= imem_data;
                        skid_pc_r    <= pc_r;
                        skid_valid_r <= 1'b1;
                        state_r      <= HOLD;
                    end else if (imem_valid) begin
                        if (imem_data == HALT_OP) begin
                            state_r  <= HALT;
                            halted_r <= 1'b1;
                        end else begin
                            state_r <= ISSUE;
                        end
                    end else begin
                        state_r <= WAIT;
                    end
                end
                HOLD: begin
                    if (load_en_s) begin
                        skid_valid_r <= 1'b0;
                        if (skid_instr_r == HALT_OP) begin
                            state_r  <= HALT;
                            halted_r <= 1'b1;
                        end else begin
                            state_r <= ISSUE;
                        end
                    end else if (!skid_valid_r) begin
                        state_r <= ISSUE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                HALT: begin
                    state_r <= HALT;
                end
                default: begin
                    state_r <= ISSUE;
                end
            endcase
        end
    end

    // The request is gated by reset so nothing is issued while reset is held.
    assign imem_rd_en         = rst && (state_r == ISSUE) && !redirect_en;
    assign imem_addr          = pc_r;
    assign instruction_output = instr_r;
    assign instr_valid        = valid_r;
    assign pc_out             = pc_out_r;
    assign halted             = halted_r;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a latency-programmable memory model answers
// requests, and every newly loaded IF/ID entry is popped against expected {instr, pc}.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_en;
    logic [7:0]  redirect_pc;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [15:0] instruction_output;
    logic        instr_valid;
    logic [7:0]  pc_out;
    logic        halted;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    int          mem_lat = 1;
    int          pend = 0;
    logic [7:0]  pend_addr = 8'h00;
    logic        req_seen = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic        prev_valid = 1'b0;

    if_stage dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .redirect_en        (redirect_en),
        .redirect_pc        (redirect_pc),
        .imem_data          (imem_data),
        .imem_valid         (imem_valid),
        .imem_rd_en         (imem_rd_en),
        .imem_addr          (imem_addr),
        .instruction_output (instruction_output),
        .instr_valid        (instr_valid),
        .pc_out             (pc_out),
        .halted             (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return (a == 8'h07) ? 16'hFFFF : (16'h1100 + {8'h00, a});
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_q(input int left, input string tag);
        int n = 0;
        while (exp_q.size() > left && n < 60) begin
            step();
            n++;
        end
        if (exp_q.size() > left) check_eq(tag, exp_q.size(), left);
    endtask

    // Capture the request the DUT actually presented at this edge.
    always @(posedge clk) begin
        req_seen <= imem_rd_en;
        req_addr <= imem_addr;
    end

    // Output monitor followed by the memory response model.
    always @(negedge clk) begin
        logic [23:0] e;
        if (instr_valid && !(stall && prev_valid)) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_instr", {8'h00, pc_out, instruction_output}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_instr", instruction_output, e[23:8]);
                check_eq("sb_pc", pc_out, e[7:0]);
            end
        end
        prev_valid = instr_valid;

        imem_valid = 1'b0;
        if (!rst) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    imem_valid = 1'b1;
                    imem_data  = mem_word(pend_addr);
                end
            end
            if (req_seen) begin
                if (mem_lat <= 1) begin
                    imem_valid = 1'b1;
                    imem_data  = mem_word(req_addr);
                end else begin
                    pend      = mem_lat - 1;
                    pend_addr = req_addr;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_instr"}, instruction_output, 16'h0000);
        check_eq({tag, "_valid"}, instr_valid, 1'b0);
        check_eq({tag, "_pc_out"}, pc_out, 8'h00);
        check_eq({tag, "_halted"}, halted, 1'b0);
        check_eq({tag, "_rd_en"}, imem_rd_en, 1'b0);
        check_eq({tag, "_addr"}, imem_addr, 8'h00);
    endtask

    initial begin
        int n;
        rst         = 1'b0;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 8'h00;
        imem_valid  = 1'b0;
        imem_data   = 16'h0000;
        step();
        step();
        check_reset_outputs("reset");

        // Sequential fetch with 1-cycle memory: request / response alternate.
        exp_q.push_back({16'h1100, 8'h00});
        exp_q.push_back({16'h1101, 8'h01});
        exp_q.push_back({16'h1102, 8'h02});
        rst = 1'b1;
        #1;
        for (int k = 0; k <= 6; k++) begin
            check_eq("rd_en_seq", imem_rd_en, (k % 2 == 0));
            if (k % 2 == 0) check_eq("addr_seq", imem_addr, k / 2);
            check_eq("valid_seq", instr_valid, (k > 0 && k % 2 == 0));
            if (k < 6) step();
        end

        // Stall arrives together with the response for 03.
        exp_q.push_back({16'h1103, 8'h03});
        exp_q.push_back({16'h1104, 8'h04});
        n = 0;
        while (!(imem_valid && imem_addr == 8'h03) && n < 20) begin
            step();
            n++;
        end
        check_eq("resp03_seen", {imem_valid, imem_addr}, {1'b1, 8'h03});
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("stall_valid", instr_valid, 1'b0);
            check_eq("stall_pc_out", pc_out, 8'h02);
            check_eq("stall_rd_en", imem_rd_en, 1'b0);
        end
        stall = 1'b0;
        step();
        check_eq("release_pc_out", pc_out, 8'h03);
        check_eq("release_valid", instr_valid, 1'b1);

        // Redirect while the request for 05 is outstanding on a slow memory.
        mem_lat = 2;
        n = 0;
        while (!(imem_rd_en && imem_addr == 8'h05) && n < 20) begin
            step();
            n++;
        end
        check_eq("reach_addr05", {imem_rd_en, imem_addr}, {1'b1, 8'h05});
        step();
        redirect_pc = 8'h40;
        redirect_en = 1'b1;
        step();
        redirect_en = 1'b0;
        mem_lat     = 1;
        #1;
        check_eq("discard_addr", imem_addr, 8'h40);
        check_eq("discard_rd_en", imem_rd_en, 1'b0);
        step();
        check_eq("post_discard_rd_en", imem_rd_en, 1'b1);
        check_eq("post_discard_addr", imem_addr, 8'h40);
        exp_q.push_back({16'h1140, 8'h40});
        wait_q(0, "timeout_40");

        // Halt at 07, then resume at 10.
        exp_q.push_back({16'h1106, 8'h06});
        exp_q.push_back({16'hFFFF, 8'h07});
        redirect_pc = 8'h06;
        redirect_en = 1'b1;
        step();
        redirect_en = 1'b0;
        wait_q(0, "timeout_halt");
        check_eq("halt_flag", halted, 1'b1);
        check_eq("halt_instr", instruction_output, 16'hFFFF);
        check_eq("halt_pc_out", pc_out, 8'h07);
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("halt_rd_en", imem_rd_en, 1'b0);
        end
        check_eq("halt_hold", halted, 1'b1);
        check_eq("halt_bubble", instr_valid, 1'b0);
        redirect_pc = 8'h10;
        redirect_en = 1'b1;
        step();
        redirect_en = 1'b0;
        #1;
        check_eq("resume_halted", halted, 1'b0);
        check_eq("resume_rd_en", imem_rd_en, 1'b1);
        check_eq("resume_addr", imem_addr, 8'h10);
        exp_q.push_back({16'h1110, 8'h10});
        wait_q(0, "timeout_10");

        // PC wrap from FF to 00.
        exp_q.push_back({16'h11FF, 8'hFF});
        exp_q.push_back({16'h1100, 8'h00});
        redirect_pc = 8'hFF;
        redirect_en = 1'b1;
        step();
        redirect_en = 1'b0;
        wait_q(1, "timeout_ff");
        check_eq("wrap_addr", imem_addr, 8'h00);
        check_eq("wrap_pc_out", pc_out, 8'hFF);
        wait_q(0, "timeout_wrap");

        // Reset while waiting on memory.
        step();
        rst = 1'b0;
        step();
        check_reset_outputs("rst_wait");
        rst = 1'b1;
        #1;
        check_eq("rst_wait_req", {imem_rd_en, imem_addr}, {1'b1, 8'h00});
        exp_q.push_back({16'h1100, 8'h00});
        wait_q(0, "timeout_rst_wait");

        // Reset while holding a stalled response in the skid buffer.
        step();
        stall = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check_reset_outputs("rst_hold");
        rst   = 1'b1;
        stall = 1'b0;
        #1;
        check_eq("rst_hold_req", {imem_rd_en, imem_addr}, {1'b1, 8'h00});
        exp_q.push_back({16'h1100, 8'h00});
        wait_q(0, "timeout_rst_hold");

        check_eq("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
